// File: rtl/osnt_stamp_pkg.sv
// Shared opcode constants and FSM state encoding for the timestamp controller.
package osnt_stamp_pkg;

  localparam logic [1:0] OP_NOP     = 2'd0;
  localparam logic [1:0] OP_LOAD    = 2'd1;
  localparam logic [1:0] OP_ADJUST  = 2'd2;
  localparam logic [1:0] OP_SET_INC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

endpackage

// File: rtl/osnt_pps_sync.sv
// Two-flop synchroniser for the asynchronous PPS input plus rising-edge detector.
module osnt_pps_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pps_i,
  output logic edge_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pps_i};
      prev_q <= sync_q[1];
    end
  end

  assign edge_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/osnt_stamp_ctrl.sv
// Timestamp counter with LOAD/ADJUST/SET_INC command FSM and optional PPS capture.
// PPS capture is built only when OSNT_STAMP_CTRL_PPS_EN is defined.
module osnt_stamp_ctrl #(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int INC_WIDTH       = 32
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       CMD_VALID,
  output logic                       CMD_READY,
  input  logic [1:0]                 CMD_OP,
  input  logic [TIMESTAMP_WIDTH-1:0] CMD_DATA,
  input  logic                       RUN,
  output logic [TIMESTAMP_WIDTH-1:0] STAMP_COUNTER,
  output logic                       STAMP_VALID,
  input  logic                       PPS_IN,
  output logic [TIMESTAMP_WIDTH-1:0] PPS_STAMP,
  output logic                       PPS_STAMP_VALID
);
  import osnt_stamp_pkg::*;

  state_e                     state_q, state_d;
  logic                       rdy_q;
  logic [1:0]                 op_q, op_d;
  logic [TIMESTAMP_WIDTH-1:0] data_q, data_d;
  logic [TIMESTAMP_WIDTH-1:0] cnt_q, cnt_d;
  logic [INC_WIDTH-1:0]       inc_q, inc_d;
  logic [TIMESTAMP_WIDTH-1:0] step;

  // READY is registered from the next state so it stays low through reset
  // and rises on the first clock edge after release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      op_q    <= OP_NOP;
      data_q  <= '0;
      cnt_q   <= '0;
      inc_q   <= INC_WIDTH'(1);
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == ST_IDLE);
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      inc_q   <= inc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID && rdy_q && (CMD_OP != OP_NOP)) begin
          op_d    = CMD_OP;
          data_d  = CMD_DATA;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign step = RUN ? TIMESTAMP_WIDTH'(inc_q) : '0;

  // SET_INC still advances by the old increment during its APPLY cycle.
  always_comb begin
    cnt_d = cnt_q + step;
    inc_d = inc_q;
    if (state_q == ST_APPLY) begin
      case (op_q)
        OP_LOAD:    cnt_d = data_q;
        OP_ADJUST:  cnt_d = cnt_q + step + data_q;
        OP_SET_INC: inc_d = data_q[INC_WIDTH-1:0];
        default:    ;
      endcase
    end
  end

  assign CMD_READY     = rdy_q;
  assign STAMP_COUNTER = cnt_q;
  assign STAMP_VALID   = rdy_q & RUN;

`ifdef OSNT_STAMP_CTRL_PPS_EN
  logic                       pps_edge;
  logic [TIMESTAMP_WIDTH-1:0] pps_stamp_q;
  logic                       pps_vld_q;

  osnt_pps_sync u_pps_sync (
    .clk_i  (ACLK),
    .rst_ni (ARESETN),
    .pps_i  (PPS_IN),
    .edge_o (pps_edge)
  );

  // Sampling cnt_q in the edge cycle yields the pre-APPLY value on a collision.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pps_stamp_q <= '0;
      pps_vld_q   <= 1'b0;
    end else begin
      pps_vld_q <= pps_edge;
      if (pps_edge) pps_stamp_q <= cnt_q;
    end
  end

  assign PPS_STAMP       = pps_stamp_q;
  assign PPS_STAMP_VALID = pps_vld_q;
`else
  logic unused_pps;
  assign unused_pps      = PPS_IN;
  assign PPS_STAMP       = '0;
  assign PPS_STAMP_VALID = 1'b0;
`endif

endmodule
